// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap
// mode, a registered one-cycle match pulse and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned     PAT_W   = 8,
  parameter int unsigned     CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1001),
  parameter int unsigned     DEF_LEN = 4,
  parameter logic            DEF_OVL = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         cfg_err
);

  localparam int unsigned      LEN_W   = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(DEF_LEN);
  localparam logic             ERR_RST = (DEF_LEN == 0) || (DEF_LEN > PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0] len_q,  len_d;
  logic             ovl_q,  ovl_d;
  logic             err_q,  err_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic [PAT_W-1:0] hist_sh;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] len_mask;
  logic             hit;

  // Next-state: config load, history shift, hit detection, counter update.
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    err_d    = err_q;
    match_d  = 1'b0;
    cnt_d    = cnt_q;
    hit      = 1'b0;
    hist_sh  = {hist_q[PAT_W-2:0], in_bit};
    fill_inc = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    for (int i = 0; i < int'(PAT_W); i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end

    if (cfg_load) begin
      // New configuration restarts detection; a bit offered now is dropped.
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      err_d  = (cfg_len == '0) || (cfg_len > LEN_MAX);
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_sh;
      fill_d = fill_inc;
      hit    = !err_q && (fill_inc >= len_q) &&
               (((hist_sh ^ pat_q) & len_mask) == '0);
      // Non-overlapping mode demands len fresh bits for the next match.
      if (hit && !ovl_q) begin
        fill_d = '0;
      end
    end

    match_d = hit;

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset to the default configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PAT;
      len_q   <= LEN_RST;
      ovl_q   <= DEF_OVL;
      err_q   <= ERR_RST;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      err_q   <= err_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default and saturating-counter
// instances share all stimulus.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       match, cfg_err, match_s, cfg_err_s;
  logic [7:0] match_count;
  logic [1:0] match_count_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detect_param u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .match(match),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detect_param #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .match(match_s),
    .match_count(match_count_s), .cfg_err(cfg_err_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic b, input logic clr);
    @(negedge clk);
    cfg_load = 1'b0;
    in_valid = v;
    in_bit   = b;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  // Send n bits, first bit = bits[n-1]; exp[i] is the match expected for bits[i].
  task automatic send(input string tag, input logic [31:0] bits, input logic [31:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0);
      check($sformatf("%s_bit%0d", tag, n - i), {31'd0, match}, {31'd0, exp[i]});
    end
    step(1'b0, 1'b0, 1'b0);
    check($sformatf("%s_idle", tag), {31'd0, match}, 32'd0);
  endtask

  // Config load with a valid 1 bit offered in the same cycle (must be dropped).
  task automatic load(input string tag, input logic [7:0] pat, input logic [3:0] len,
                      input logic ovl, input logic exp_err);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    cnt_clr     = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_match"}, {31'd0, match}, 32'd0);
    check({tag, "_err"}, {31'd0, cfg_err}, {31'd0, exp_err});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'd0; cfg_len = 4'd0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    #3;
    check("rst_match", {31'd0, match}, 32'd0);
    check("rst_count", {24'd0, match_count}, 32'd0);
    check("rst_err",   {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default 1001, overlapping.
    send("ovl", 32'b1001001, 32'b0001001, 7);
    check("ovl_count", {24'd0, match_count}, 32'd2);
    check("ovl_count_sat", {30'd0, match_count_s}, 32'd2);

    // Non-overlapping.
    load("ld_novl", 8'b0000_1001, 4'd4, 1'b0, 1'b0);
    send("novl", 32'b1001001, 32'b0001000, 7);
    check("novl_count", {24'd0, match_count}, 32'd3);

    // Pattern bits above len-1 ignored: effective pattern 101.
    load("ld_p3", 8'b1111_0101, 4'd3, 1'b1, 1'b0);
    send("p3", 32'b10101, 32'b00101, 5);
    check("p3_count", {24'd0, match_count}, 32'd5);

    // Full-width all-ones pattern, overlapping.
    load("ld_ff", 8'hFF, 4'd8, 1'b1, 1'b0);
    send("ff", 32'h3FF, 32'b0000000111, 10);
    check("ff_count", {24'd0, match_count}, 32'd8);
    // History and fill held across the idle cycle.
    send("hold", 32'b1, 32'b1, 1);
    check("hold_count", {24'd0, match_count}, 32'd9);

    // Illegal lengths.
    load("ld_len0", 8'h00, 4'd0, 1'b1, 1'b1);
    send("len0", 32'b1001, 32'b0000, 4);
    check("len0_count", {24'd0, match_count}, 32'd9);
    load("ld_len9", 8'hFF, 4'd9, 1'b1, 1'b1);
    send("len9", 32'h3FF, 32'd0, 10);
    check("len9_count", {24'd0, match_count}, 32'd9);

    // Saturation and clear priority.
    load("ld_sat", 8'b0000_1001, 4'd4, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("clr_count", {24'd0, match_count}, 32'd0);
    check("clr_count_sat", {30'd0, match_count_s}, 32'd0);
    send("sat", 32'b1001001001001001, 32'b0001001001001001, 16);
    check("sat_count", {24'd0, match_count}, 32'd5);
    check("sat_count_sat", {30'd0, match_count_s}, 32'd3);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clrhit_match", {31'd0, match}, 32'd1);
    check("clrhit_count", {24'd0, match_count}, 32'd0);
    check("clrhit_count_sat", {30'd0, match_count_s}, 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // Reset mid-sequence restores defaults and discards partial input.
    load("ld_pre", 8'b0000_0110, 4'd4, 1'b0, 1'b0);
    send("pre", 32'b100, 32'b000, 3);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_count", {24'd0, match_count}, 32'd0);
    check("arst_match", {31'd0, match}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send("post", 32'b11001, 32'b00001, 5);
    send("post_ovl", 32'b001, 32'b001, 3);
    check("post_count", {24'd0, match_count}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 8: maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 8: width of match counter.
REQ-003 SHALL have parameter DEF_PAT, default 8'b0000_1001: pattern loaded at reset.
REQ-004 SHALL have parameter DEF_LEN, default 4: pattern length loaded at reset.
REQ-005 SHALL have parameter DEF_OVL, default 1: overlap mode loaded at reset.
REQ-006 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid  input  1  in_bit is sampled this cycle.
REQ-009 SHALL have port in_bit  input  1  serial data bit.
REQ-010 SHALL have port cfg_load  input  1  single-cycle pulse; latches cfg_pattern, cfg_len, cfg_overlap.
REQ-011 SHALL have port cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last.
REQ-012 SHALL have port cfg_len  input  $clog2(PAT_W+1)  pattern length in bits.
REQ-013 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-014 SHALL have port cnt_clr  input  1  synchronous clear of match_count.
REQ-015 SHALL have port match  output  1  one-cycle pulse per detected pattern.
REQ-016 SHALL have port match_count  output  CNT_W  saturating count of matches.
REQ-017 SHALL have port cfg_err  output  1  latched length is illegal.

Function
REQ-018 SHALL keep a PAT_W-bit history register; on each in_valid cycle, shift left and insert in_bit at bit 0 (bit 0 = newest).
REQ-019 SHALL keep a fill counter of valid history bits, incremented per accepted bit and saturating at PAT_W.
REQ-020 SHALL flag a hit on an accepted bit when fill (including the new bit) >= len and history[len-1:0] (including the new bit) == pattern[len-1:0].
REQ-021 SHALL register match: match = 1 in the cycle after the completing bit is accepted (latency 1), 0 otherwise.
REQ-022 Overlap mode 1: the history and fill counter SHALL be kept after a hit, so a suffix can start the next match.
REQ-023 Overlap mode 0: the fill counter SHALL be cleared to 0 on a hit, so the next match needs len fresh bits.
REQ-024 When in_valid = 0, history, fill and match SHALL hold, except that match drops to 0.
REQ-025 On cfg_load, the block SHALL latch the cfg inputs, clear history and fill, and drop match to 0 next cycle; a bit presented in the same cycle is discarded.
REQ-026 SHALL set cfg_err = 1 when the latched len is 0 or len > PAT_W; while cfg_err = 1, no hit is flagged and match_count holds.
REQ-027 SHALL increment match_count by 1 per hit and saturate at 2^CNT_W-1.
REQ-028 On cnt_clr, match_count SHALL become 0; when cnt_clr and a hit occur in the same cycle, cnt_clr wins (result 0); match still pulses.
REQ-029 Pattern bits above len-1 SHALL be ignored.

Reset
REQ-030 While rst_n = 0, asynchronously and independent of clk: history = 0, fill = 0, match = 0, match_count = 0, pattern = DEF_PAT, len = DEF_LEN, overlap = DEF_OVL, cfg_err = (DEF_LEN illegal).
REQ-031 Reset mid-sequence SHALL discard the partial sequence; after release, a match requires len fresh bits.

Verification
REQ-032 Defaults (pattern 1001, len 4, overlap 1), stream 1,0,0,1,0,0,1 -> match pulses after bit 4 and after bit 7; match_count = 2.
REQ-033 cfg_load pattern 1001, len 4, overlap 0; same stream -> single match after bit 4; match_count = 1.
REQ-034 cfg_load pattern 8'b1111_1111, len 8; 10 consecutive 1s in overlap mode -> matches after bits 8, 9, 10.
REQ-035 cfg_len = 0, then any stream -> cfg_err = 1, no match, match_count holds.
REQ-036 CNT_W = 2, 5 matches -> match_count saturates at 3; cnt_clr in the same cycle as a hit -> match_count = 0, match = 1.
REQ-037 rst_n pulsed low after bits 1,0,0, then bit 1 -> no match; full 1,0,0,1 afterwards -> match.
